fp_comp_arbiter: RTL and testbench

FP_COMP_ARBITER -- requirements
Module: fp_comp_arbiter

---
 rtl/fp_comp_arbiter.sv | 139 +++++++++++++
 tb/tb_fp_comp_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_comp_arbiter.sv
// Round-robin arbiter sharing one floating-point comparator among N_REQ requesters.
// An in-order tag FIFO routes each comparator result back to the requester that issued it.
module fp_comp_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_dataa,
    input  logic [N_REQ*32-1:0]   req_datab,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic                  rsp_agb,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic                  cmp_snk_valid,
    output logic [31:0]           cmp_snk_dataa,
    output logic [31:0]           cmp_snk_datab,
    input  logic                  cmp_snk_ready,
    input  logic                  cmp_src_valid,
    input  logic                  cmp_src_agb,
    output logic                  cmp_src_ready
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(TAG_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W-1:0] tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [IDX_W-1:0] grant_s;
    logic             grant_found_s;
    logic [IDX_W-1:0] head_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    assign empty_s = (count_r == {(PTR_W + 1){1'b0}});
    assign full_s  = (count_r == FULL_CNT);
    assign head_s  = tag_mem_r[rd_ptr_r];

    // Round-robin search starting one past the last granted requester
    always_comb begin : grant_search
        logic [IDX_W:0] sum_s;
        logic [IDX_W-1:0] cand_s;
        grant_s       = last_grant_r;
        grant_found_s = 1'b0;
        sum_s         = '0;
        cand_s        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum_s = {1'b0, last_grant_r} + (IDX_W + 1)'(k);
            if (sum_s >= N_REQ_W) begin
                sum_s = sum_s - N_REQ_W;
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_s       = cand_s;
                grant_found_s = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Issue and response routing; everything is gated off while rst is low
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_agb       = cmp_src_agb;
        cmp_snk_valid = 1'b0;
        cmp_snk_dataa = 32'h0000_0000;
        cmp_snk_datab = 32'h0000_0000;
        cmp_src_ready = 1'b0;
        pop_s         = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s == IDX_W'(i)) begin
                cmp_snk_dataa = req_dataa[i*32 +: 32];
                cmp_snk_datab = req_datab[i*32 +: 32];
            end else begin
                cmp_snk_dataa = cmp_snk_dataa;
            end
        end
        // A result with no outstanding tag is never routed or accepted
        if (rst && !empty_s) begin
            rsp_valid[head_s] = cmp_src_valid;
            cmp_src_ready     = rsp_ready[head_s];
            pop_s             = cmp_src_valid && rsp_ready[head_s];
        end else begin
            pop_s = 1'b0;
        end
        // A full FIFO can still accept a tag when the head pops in the same cycle
        if (rst && grant_found_s && (!full_s || pop_s)) begin
            cmp_snk_valid      = 1'b1;
            req_ready[grant_s] = cmp_snk_ready;
        end else begin
            cmp_snk_valid = 1'b0;
        end
        push_s = cmp_snk_valid && cmp_snk_ready;
    end

    // Tag FIFO and last-grant state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= LAST_RST;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
                last_grant_r        <= grant_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_comp_arbiter.sv
// Bench for fp_comp_arbiter: behavioural comparator with fixed latency, a grant/tag
// reference model with a response scoreboard, a vector table and corner-case sequences.
module tb_fp_comp_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_dataa, req_datab;
    logic            rsp_agb, cmp_snk_valid, cmp_snk_ready;
    logic            cmp_src_valid, cmp_src_agb, cmp_src_ready;
    logic [31:0]     cmp_snk_dataa, cmp_snk_datab;

    typedef struct { logic [1:0] idx; logic agb; } exp_t;
    typedef struct { logic agb; int due; } cmp_t;
    typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic agb; } vec_t;

    exp_t exp_q[$];
    cmp_t cq[$];
    vec_t vt[7];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 3;
    int n_iss    = 0;
    int n_rsp    = 0;
    logic [1:0] last_m;
    logic force_src;
    logic got_issue, got_rsp, got_rsp_agb;
    logic [1:0] got_grant, got_rsp_idx;

    always #5 clk = ~clk;

    fp_comp_arbiter #(.N_REQ(N), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_agb(rsp_agb),
        .rsp_ready(rsp_ready), .cmp_snk_valid(cmp_snk_valid),
        .cmp_snk_dataa(cmp_snk_dataa), .cmp_snk_datab(cmp_snk_datab),
        .cmp_snk_ready(cmp_snk_ready), .cmp_src_valid(cmp_src_valid),
        .cmp_src_agb(cmp_src_agb), .cmp_src_ready(cmp_src_ready)
    );

    // IEEE-754 single A > B, NaN-free; +0 and -0 compare equal
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_src();
        if (force_src) cmp_src_valid = 1'b1;
        else cmp_src_valid = (cq.size() > 0) && (cq[0].due <= cyc);
        cmp_src_agb = (cq.size() > 0) ? cq[0].agb : 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance model and comparator
    task automatic run_cycle();
        logic [N-1:0] exp_rr, exp_rv;
        logic exp_sv, exp_cr, exp_pop, found, act_push, act_pop, push_agb, new_agb;
        logic [1:0] g, head, c;
        int gi;
        @(negedge clk);
        exp_rr = '0; exp_rv = '0; exp_sv = 1'b0; exp_cr = 1'b0; exp_pop = 1'b0;
        found = 1'b0; g = 2'd0; head = 2'd0; c = 2'd0; new_agb = 1'b0;
        if (rst) begin
            if (exp_q.size() > 0) begin
                head = exp_q[0].idx;
                exp_cr = rsp_ready[head];
                exp_rv[head] = cmp_src_valid;
                exp_pop = cmp_src_valid && rsp_ready[head];
            end
            for (int k = 1; k <= N; k++) begin
                c = last_m + 2'(k);
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
            exp_sv = found && (exp_q.size() < DEPTH || exp_pop);
            if (exp_sv && cmp_snk_ready) exp_rr[g] = 1'b1;
        end
        gi = int'(g);
        check("cmp_snk_valid", 32'(cmp_snk_valid), 32'(exp_sv));
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("cmp_src_ready", 32'(cmp_src_ready), 32'(exp_cr));
        if (exp_sv) begin
            check("snk_dataa", cmp_snk_dataa, req_dataa[gi*32 +: 32]);
            check("snk_datab", cmp_snk_datab, req_datab[gi*32 +: 32]);
            new_agb = fp_gt(req_dataa[gi*32 +: 32], req_datab[gi*32 +: 32]);
        end
        if (exp_pop) check("rsp_agb", 32'(rsp_agb), 32'(exp_q[0].agb));
        got_issue = cmp_snk_valid && cmp_snk_ready;
        got_rsp = cmp_src_valid && cmp_src_ready;
        got_rsp_agb = rsp_agb;
        got_grant = 2'd0;
        got_rsp_idx = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) got_grant = 2'(i);
            if (rsp_valid[i]) got_rsp_idx = 2'(i);
        end
        act_push = got_issue;
        push_agb = fp_gt(cmp_snk_dataa, cmp_snk_datab);
        act_pop = got_rsp && (cq.size() > 0);
        @(posedge clk);
        #1;
        cyc++;
        if (got_issue) n_iss++;
        if (got_rsp) n_rsp++;
        if (!rst) begin
            exp_q.delete();
            cq.delete();
            last_m = 2'(N - 1);
        end else begin
            if (exp_pop) void'(exp_q.pop_front());
            if (exp_sv && cmp_snk_ready) begin
                exp_q.push_back('{idx: g, agb: new_agb});
                last_m = g;
            end
            if (act_pop) void'(cq.pop_front());
            if (act_push) cq.push_back('{agb: push_agb, due: cyc + lat - 1});
        end
        update_src();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run_cycle();
        run_cycle();
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) run_cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        int issues, results, saved;
        logic done;
        vt[0] = '{2, 32'h4000_0000, 32'h3F80_0000, 1'b1};
        vt[1] = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0};
        vt[2] = '{1, 32'hC000_0000, 32'hBF80_0000, 1'b0};
        vt[3] = '{3, 32'hBF80_0000, 32'hC000_0000, 1'b1};
        vt[4] = '{2, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vt[5] = '{0, 32'h7F80_0000, 32'h7F7F_FFFF, 1'b1};
        vt[6] = '{1, 32'h3F80_0000, 32'h3F80_0000, 1'b0};

        // Reset with requests pending and a spurious result: all outputs must stay low
        rst = 1'b0; req_valid = 4'b1111; rsp_ready = 4'b1111; cmp_snk_ready = 1'b1;
        force_src = 1'b1; last_m = 2'd3;
        for (int i = 0; i < N; i++) begin
            req_dataa[i*32 +: 32] = 32'h3F80_0000 + 32'(i);
            req_datab[i*32 +: 32] = 32'h3F80_0000;
        end
        update_src();
        run_cycle();
        run_cycle();
        force_src = 1'b0; req_valid = 4'b0000;
        update_src();
        rst = 1'b1;

        // Single-requester vectors
        for (int v = 0; v < 7; v++) begin
            req_dataa[vt[v].idx*32 +: 32] = vt[v].a;
            req_datab[vt[v].idx*32 +: 32] = vt[v].b;
            req_valid = 4'b0001 << vt[v].idx;
            done = 1'b0;
            for (int t = 0; t < 30 && !done; t++) begin
                run_cycle();
                if (got_issue) req_valid = 4'b0000;
                if (got_rsp) begin
                    done = 1'b1;
                    check("vec_rsp_idx", 32'(got_rsp_idx), 32'(vt[v].idx));
                    check("vec_rsp_agb", 32'(got_rsp_agb), 32'(vt[v].agb));
                end
            end
            check("vec_done", 32'(done), 32'd1);
        end

        // Round-robin order with all requesters active
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            check("rr_issue", 32'(got_issue), 32'd1);
            check("rr_grant", 32'(got_grant), 32'(i % 4));
        end
        req_valid = 4'b0000;
        drain();

        // Head-of-line blocking fills the FIFO, then drains in order
        do_reset();
        req_valid = 4'b1111; rsp_ready = 4'b1110;
        issues = n_iss;
        repeat (20) run_cycle();
        check("hol_issues", 32'(n_iss - issues), 32'd8);
        check("hol_blocked", 32'(req_ready), 32'd0);
        req_valid = 4'b0000; rsp_ready = 4'b1111;
        results = n_rsp;
        drain();
        check("hol_results", 32'(n_rsp - results), 32'd8);

        // Full FIFO: pop and push in the same cycle, then full again
        do_reset();
        req_valid = 4'b1111; rsp_ready = 4'b1110;
        repeat (12) run_cycle();
        rsp_ready = 4'b1111;
        run_cycle();
        check("full_push", 32'(got_issue), 32'd1);
        check("full_pop", 32'(got_rsp), 32'd1);
        rsp_ready = 4'b0000;
        run_cycle();
        check("full_hold", 32'(got_issue), 32'd0);
        req_valid = 4'b0000; rsp_ready = 4'b1111;
        drain();

        // Comparator sink stall keeps last_grant
        do_reset();
        req_valid = 4'b1111;
        run_cycle();
        run_cycle();
        saved = int'(got_grant);
        check("stall_pre_grant", 32'(saved), 32'd1);
        cmp_snk_ready = 1'b0;
        issues = n_iss;
        repeat (5) run_cycle();
        check("stall_no_issue", 32'(n_iss - issues), 32'd0);
        cmp_snk_ready = 1'b1;
        run_cycle();
        check("stall_resume", 32'(got_grant), 32'd2);
        req_valid = 4'b0000;
        drain();

        // Result with empty FIFO is ignored
        force_src = 1'b1;
        update_src();
        #1;
        check("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
        check("orphan_src_ready", 32'(cmp_src_ready), 32'd0);
        run_cycle();
        force_src = 1'b0;
        update_src();

        // Reset mid-operation with three outstanding tags
        do_reset();
        req_valid = 4'b1111; rsp_ready = 4'b0000;
        repeat (3) run_cycle();
        check("pre_rst_outstanding", 32'(exp_q.size()), 32'd3);
        rst = 1'b0; force_src = 1'b1;
        update_src();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_snk_valid", 32'(cmp_snk_valid), 32'd0);
        check("rst_src_ready", 32'(cmp_src_ready), 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b1; force_src = 1'b0; rsp_ready = 4'b1111;
        update_src();
        run_cycle();
        check("rst_first_issue", 32'(got_issue), 32'd1);
        check("rst_first_grant", 32'(got_grant), 32'd0);
        repeat (3) run_cycle();
        req_valid = 4'b0000;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
